// File: rtl/router_pkg.sv
// Router-wide constants and header helpers shared by the FSM, FIFO and
// register block.
package router_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LEN_LSB    = 2;
    localparam int DEST_W     = 2;

    // Header is {len, dest}; the length field starts at LEN_LSB.
    function automatic logic [31:0] hdr_len(input logic [31:0] hdr);
        return hdr >> LEN_LSB;
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Flit storage for the egress FIFO: synchronous write,
// combinational read at the read address.
module router_fifo_mem #(
    parameter int W     = 9,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware egress FIFO: occupancy flags, remaining-length tracking
// of the packet being read, and sticky overflow/underflow errors.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     soft_reset,
    input  logic                     write_enb,
    input  logic                     sof_in,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     read_enb,
    output logic [DATA_W-1:0]        data_out,
    output logic                     sof_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DATA_W-2:0]        pkt_rem,
    output logic                     pkt_last,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_LVL = (AW+1)'(AF_LEVEL);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W:0]   rd_entry;
    logic [DATA_W-2:0] hdr_rem;
    logic              wr_acc;
    logic              rd_acc;

    assign full        = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign empty       = (wr_ptr == rd_ptr);
    assign level       = wr_ptr - rd_ptr;
    assign almost_full = (level >= AF_LVL);

    assign wr_acc = write_enb && !full;
    assign rd_acc = read_enb && !empty;

    // len+1 covers payload plus parity flit.
    assign hdr_rem = (DATA_W-1)'(
        hdr_len(32'(rd_entry[DATA_W-1:0])) + 32'd1);

    router_fifo_mem #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (wr_acc && resetn && !soft_reset),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({sof_in, data_in}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry)
    );

    always_ff @(posedge clock) begin
        if (!resetn || soft_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            data_out  <= '0;
            sof_out   <= 1'b0;
            pkt_rem   <= '0;
            pkt_last  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pkt_last <= 1'b0;
            if (write_enb && full) begin
                overflow <= 1'b1;
            end
            if (read_enb && empty) begin
                underflow <= 1'b1;
            end
            if (wr_acc) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + (AW+1)'(1);
                data_out <= rd_entry[DATA_W-1:0];
                sof_out  <= rd_entry[DATA_W];
                if (rd_entry[DATA_W]) begin
                    pkt_rem <= hdr_rem;
                end else if (pkt_rem != '0) begin
                    pkt_rem  <= pkt_rem - (DATA_W-1)'(1);
                    pkt_last <= (pkt_rem == (DATA_W-1)'(1));
                end
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed checks on the 8x16 FIFO plus randomized scoreboard
// traffic on a 4x4 instance.
module tb_router_pkt_fifo;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    // 8-bit, 16-deep instance
    logic       a_srst = 0, a_we = 0, a_sof = 0, a_re = 0;
    logic [7:0] a_din = 0, a_dout;
    logic       a_sofo, a_full, a_empty, a_af, a_last, a_ovf, a_udf;
    logic [4:0] a_level;
    logic [6:0] a_rem;

    // 4-bit, 4-deep instance
    logic       b_srst = 0, b_we = 0, b_sof = 0, b_re = 0;
    logic [3:0] b_din = 0, b_dout;
    logic       b_sofo, b_full, b_empty, b_af, b_last, b_ovf, b_udf;
    logic [2:0] b_level;
    logic [2:0] b_rem;

    router_pkt_fifo #(.DATA_W(8), .DEPTH(16)) dut_a (
        .clock(clock), .resetn(resetn), .soft_reset(a_srst),
        .write_enb(a_we), .sof_in(a_sof), .data_in(a_din),
        .read_enb(a_re), .data_out(a_dout), .sof_out(a_sofo),
        .full(a_full), .empty(a_empty), .almost_full(a_af),
        .level(a_level), .pkt_rem(a_rem), .pkt_last(a_last),
        .overflow(a_ovf), .underflow(a_udf)
    );

    router_pkt_fifo #(.DATA_W(4), .DEPTH(4)) dut_b (
        .clock(clock), .resetn(resetn), .soft_reset(b_srst),
        .write_enb(b_we), .sof_in(b_sof), .data_in(b_din),
        .read_enb(b_re), .data_out(b_dout), .sof_out(b_sofo),
        .full(b_full), .empty(b_empty), .almost_full(b_af),
        .level(b_level), .pkt_rem(b_rem), .pkt_last(b_last),
        .overflow(b_ovf), .underflow(b_udf)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
    endtask

    task automatic wr_a(input logic s, input logic [7:0] d);
        a_we = 1; a_sof = s; a_din = d;
        cyc();
        a_we = 0; a_sof = 0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cyc(); cyc();
        resetn = 1'b1;
        total += 6;
        if (a_dout !== 8'h00) begin bad++; $display("FAIL rst_dout got=%h exp=00", a_dout); end
        if (a_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", a_empty); end
        if (a_full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", a_full); end
        if (a_level !== 5'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", a_level); end
        if (a_rem !== 7'd0) begin bad++; $display("FAIL rst_rem got=%0d exp=0", a_rem); end
        if (b_empty !== 1'b1) begin bad++; $display("FAIL rst_b_empty got=%b exp=1", b_empty); end
    endtask

    task automatic test_fill();
        logic [7:0] d [16];
        do_reset();
        for (int i = 0; i < 16; i++) begin
            d[i] = 8'($urandom);
            wr_a(1'b0, d[i]);
            total += 2;
            if (a_level !== 5'(i + 1)) begin bad++; $display("FAIL fill_level got=%0d exp=%0d", a_level, i + 1); end
            if (a_af !== (i + 1 >= 14)) begin bad++; $display("FAIL fill_af got=%b exp=%b lvl=%0d", a_af, (i + 1 >= 14), i + 1); end
        end
        total += 2;
        if (a_full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", a_full); end
        if (a_ovf !== 1'b0) begin bad++; $display("FAIL fill_ovf_early got=%b exp=0", a_ovf); end
        wr_a(1'b0, ~d[0]);
        total += 2;
        if (a_ovf !== 1'b1) begin bad++; $display("FAIL ovf got=%b exp=1", a_ovf); end
        if (a_level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d exp=16", a_level); end
        for (int i = 0; i < 16; i++) begin
            a_re = 1;
            cyc();
            total++;
            if (a_dout !== d[i]) begin bad++; $display("FAIL fill_rd%0d got=%h exp=%h", i, a_dout, d[i]); end
        end
        a_re = 0;
        total += 2;
        if (a_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", a_empty); end
        if (a_udf !== 1'b0) begin bad++; $display("FAIL drain_udf got=%b exp=0", a_udf); end
    endtask

    task automatic test_packet();
        logic [7:0] pk [5];
        int er [5] = '{4, 3, 2, 1, 0};
        do_reset();
        pk[0] = 8'h0D;
        for (int i = 1; i < 5; i++) pk[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) wr_a(i == 0, pk[i]);
        for (int i = 0; i < 5; i++) begin
            a_re = 1;
            cyc();
            total += 4;
            if (a_dout !== pk[i]) begin bad++; $display("FAIL pkt_data%0d got=%h exp=%h", i, a_dout, pk[i]); end
            if (a_sofo !== (i == 0)) begin bad++; $display("FAIL pkt_sof%0d got=%b exp=%b", i, a_sofo, (i == 0)); end
            if (a_rem !== 7'(er[i])) begin bad++; $display("FAIL pkt_rem%0d got=%0d exp=%0d", i, a_rem, er[i]); end
            if (a_last !== (i == 4)) begin bad++; $display("FAIL pkt_last%0d got=%b exp=%b", i, a_last, (i == 4)); end
        end
        a_re = 0;
        cyc();
        total += 2;
        if (a_last !== 1'b0) begin bad++; $display("FAIL pkt_last_pulse got=%b exp=0", a_last); end
        if (a_dout !== pk[4]) begin bad++; $display("FAIL pkt_hold got=%h exp=%h", a_dout, pk[4]); end
    endtask

    task automatic test_full_rw();
        logic [7:0] first;
        do_reset();
        first = 8'($urandom);
        wr_a(1'b0, first);
        for (int i = 1; i < 16; i++) wr_a(1'b0, 8'($urandom));
        a_we = 1; a_re = 1; a_din = 8'hA5;
        cyc();
        a_we = 0; a_re = 0;
        total += 3;
        if (a_level !== 5'd15) begin bad++; $display("FAIL full_rw_level got=%0d exp=15", a_level); end
        if (a_dout !== first) begin bad++; $display("FAIL full_rw_data got=%h exp=%h", a_dout, first); end
        if (a_full !== 1'b0) begin bad++; $display("FAIL full_rw_full got=%b exp=0", a_full); end
        do_reset();
        a_we = 1; a_re = 1; a_din = 8'h5A;
        cyc();
        a_we = 0; a_re = 0;
        total += 3;
        if (a_level !== 5'd1) begin bad++; $display("FAIL empty_rw_level got=%0d exp=1", a_level); end
        if (a_dout !== 8'h00) begin bad++; $display("FAIL empty_rw_hold got=%h exp=00", a_dout); end
        if (a_udf !== 1'b1) begin bad++; $display("FAIL empty_rw_udf got=%b exp=1", a_udf); end
        a_re = 1;
        cyc();
        a_re = 0;
        total++;
        if (a_dout !== 8'h5A) begin bad++; $display("FAIL empty_rw_rd got=%h exp=5a", a_dout); end
    endtask

    task automatic test_soft_reset();
        do_reset();
        wr_a(1'b1, 8'h0D);
        for (int i = 0; i < 7; i++) wr_a(1'b0, 8'($urandom));
        a_re = 1;
        cyc(); cyc(); cyc();
        a_re = 0;
        total += 2;
        if (a_rem !== 7'd2) begin bad++; $display("FAIL srst_pre_rem got=%0d exp=2", a_rem); end
        if (a_level !== 5'd5) begin bad++; $display("FAIL srst_pre_level got=%0d exp=5", a_level); end
        a_srst = 1; a_we = 1; a_din = 8'hFF;
        cyc();
        a_srst = 0; a_we = 0;
        total += 5;
        if (a_level !== 5'd0) begin bad++; $display("FAIL srst_level got=%0d exp=0", a_level); end
        if (a_empty !== 1'b1) begin bad++; $display("FAIL srst_empty got=%b exp=1", a_empty); end
        if (a_rem !== 7'd0) begin bad++; $display("FAIL srst_rem got=%0d exp=0", a_rem); end
        if (a_dout !== 8'h00) begin bad++; $display("FAIL srst_dout got=%h exp=00", a_dout); end
        if (a_sofo !== 1'b0) begin bad++; $display("FAIL srst_sof got=%b exp=0", a_sofo); end
        cyc();
        total++;
        if (a_empty !== 1'b1) begin bad++; $display("FAIL srst_drop got=%b exp=1", a_empty); end
    endtask

    task automatic test_underflow();
        do_reset();
        a_re = 1;
        cyc();
        a_re = 0;
        total++;
        if (a_udf !== 1'b1) begin bad++; $display("FAIL udf_set got=%b exp=1", a_udf); end
        wr_a(1'b1, 8'h0D);
        wr_a(1'b0, 8'h33);
        a_re = 1;
        cyc();
        a_re = 0;
        total += 2;
        if (a_udf !== 1'b1) begin bad++; $display("FAIL udf_sticky got=%b exp=1", a_udf); end
        if (a_rem !== 7'd4) begin bad++; $display("FAIL udf_rem got=%0d exp=4", a_rem); end
        do_reset();
        total += 9;
        if (a_dout !== 8'h00) begin bad++; $display("FAIL rst2_dout got=%h exp=00", a_dout); end
        if (a_sofo !== 1'b0) begin bad++; $display("FAIL rst2_sof got=%b exp=0", a_sofo); end
        if (a_rem !== 7'd0) begin bad++; $display("FAIL rst2_rem got=%0d exp=0", a_rem); end
        if (a_level !== 5'd0) begin bad++; $display("FAIL rst2_level got=%0d exp=0", a_level); end
        if (a_empty !== 1'b1) begin bad++; $display("FAIL rst2_empty got=%b exp=1", a_empty); end
        if (a_full !== 1'b0) begin bad++; $display("FAIL rst2_full got=%b exp=0", a_full); end
        if (a_af !== 1'b0) begin bad++; $display("FAIL rst2_af got=%b exp=0", a_af); end
        if (a_udf !== 1'b0) begin bad++; $display("FAIL rst2_udf got=%b exp=0", a_udf); end
        if (a_last !== 1'b0) begin bad++; $display("FAIL rst2_last got=%b exp=0", a_last); end
    endtask

    task automatic test_random_small();
        logic [4:0] q [$];
        logic [4:0] e;
        logic [3:0] m_dout = 0;
        logic       m_sof = 0, m_last = 0, m_ovf = 0, m_udf = 0;
        int         m_rem = 0;
        int         wbias = 50;
        int         shown = 0;
        logic       f, em, ok;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) wbias = $urandom_range(15, 85);
            b_we   = ($urandom_range(0, 99) < wbias);
            b_re   = ($urandom_range(0, 99) >= wbias);
            b_sof  = ($urandom_range(0, 3) == 0);
            b_din  = 4'($urandom);
            b_srst = ($urandom_range(0, 99) == 0);
            if (b_srst) begin
                q.delete();
                m_dout = 0; m_sof = 0; m_rem = 0;
                m_last = 0; m_ovf = 0; m_udf = 0;
            end else begin
                f  = (q.size() == 4);
                em = (q.size() == 0);
                m_last = 0;
                if (b_we && f) m_ovf = 1;
                if (b_re && em) m_udf = 1;
                if (b_re && !em) begin
                    e = q.pop_front();
                    m_dout = e[3:0];
                    m_sof  = e[4];
                    if (m_sof) m_rem = int'(e[3:2]) + 1;
                    else if (m_rem != 0) begin
                        m_last = (m_rem == 1);
                        m_rem--;
                    end
                end
                if (b_we && !f) q.push_back({b_sof, b_din});
            end
            cyc();
            ok = (b_level === 3'(q.size())) && (b_full === (q.size() == 4))
              && (b_empty === (q.size() == 0)) && (b_af === (q.size() >= 2))
              && (b_dout === m_dout) && (b_sofo === m_sof)
              && (b_rem === 3'(m_rem)) && (b_last === m_last)
              && (b_ovf === m_ovf) && (b_udf === m_udf);
            total++;
            if (!ok) begin
                bad++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL rand_c%0d got lvl=%0d f=%b e=%b af=%b d=%h s=%b rem=%0d l=%b o=%b u=%b exp lvl=%0d d=%h s=%b rem=%0d l=%b o=%b u=%b",
                             c, b_level, b_full, b_empty, b_af, b_dout, b_sofo, b_rem, b_last, b_ovf, b_udf,
                             q.size(), m_dout, m_sof, m_rem, m_last, m_ovf, m_udf);
                end
            end
        end
        b_we = 0; b_re = 0; b_srst = 0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_packet();
        test_full_rw();
        test_soft_reset();
        test_underflow();
        test_random_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_pkt_fifo.md
# router_pkt_fifo

Parametrised, packet-aware output FIFO for one router egress channel. Stores DATA_W-bit flits with a start-of-frame marker. Tracks the remaining length of the packet currently being read, using the header length field, and reports occupancy and sticky overflow/underflow errors. Sits between the router synchroniser/FSM (write side) and the egress port (read side); replaces the fixed 3-bit, 16-deep channel FIFO.

## Interface
- DATA_W, 8: flit width; header layout {len[DATA_W-1:2], dest[1:0]}; min 4
- DEPTH, 16: entries; power of two, ≥4
- AF_LEVEL, DEPTH-2: level at or above which almost_full asserts
- AW (derived), log2(DEPTH)
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- soft_reset  in  1  synchronous flush (channel timeout), active-high
- write_enb  in  1  write request
- sof_in  in  1  data_in is a header flit
- data_in  in  DATA_W  write flit
- read_enb  in  1  read request
- data_out  out  DATA_W  registered read flit
- sof_out  out  1  registered marker of data_out
- full / empty  out  1  occupancy flags
- almost_full  out  1  level ≥ AF_LEVEL
- level  out  AW+1  entries stored, 0..DEPTH
- pkt_rem  out  DATA_W-1  flits left in current packet (payload+parity)
- pkt_last  out  1  one-cycle pulse: last flit of packet read
- overflow / underflow  out  1  sticky error flags

## Operation
- Storage: DEPTH × (DATA_W+1) entries {sof, data}. Pointers are AW+1 bits. full = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]}). empty = (wr_ptr == rd_ptr).
- Write accepted iff write_enb && !full, with full taken pre-edge. Read accepted iff read_enb && !empty, with empty taken pre-edge.
- Accepted read: data_out/sof_out ← entry at rd_ptr, rd_ptr+1. No accepted read: data_out/sof_out hold. Never tri-stated.
- Simultaneous accepted read+write: level unchanged. When full, only the read is accepted. When empty, only the write is accepted; the flit is not bypassed.
- Packet counter, updated on an accepted read:
  - sof entry: pkt_rem ← len+1, where len = data[DATA_W-1:2] zero-extended (len+1 counts payload + parity).
  - Non-sof entry with pkt_rem≠0: pkt_rem−1. pkt_last=1 when the old value was 1.
  - Non-sof entry with pkt_rem=0: pkt_rem holds (stray flit).
  - A sof read while pkt_rem≠0 reloads the counter; no pulse.
- Errors: overflow sets on write_enb && full. underflow sets on read_enb && empty. Both stay set until reset or soft_reset.
- Precedence: resetn > soft_reset > read/write. soft_reset drops any same-cycle read/write. It clears pointers, level, pkt_rem, pkt_last, errors, data_out, sof_out.
- Reset values: data_out 0, sof_out 0, full 0, empty 1, almost_full 0, level 0, pkt_rem 0, pkt_last 0, overflow 0, underflow 0. Memory contents need not be cleared.

## Timing
- Read latency 1: data_out valid the cycle after an accepted read.
- Write-to-read: flit written at edge N is readable at N+1 (empty deasserts after edge N).
- full, empty, almost_full, level are registered or derived from registered pointers, and update on the edge of the accepted access.
- pkt_last is high in the same cycle data_out shows the last flit.
- Wrap-around: pointers roll naturally at 2·DEPTH; the MSB toggle distinguishes full from empty.

## Structure
- router_pkg: DATA_W default, header field positions (LEN_LSB=2, DEST_W=2), hdr_len() function. Shared with the router FSM and register block.
- Sub-module router_fifo_mem: DEPTH×(DATA_W+1) storage, synchronous write, combinational read at rd address. Pointers, flags and packet counter live in the top.

## Test plan
- Reset, then write 16 flits (DEPTH=16) without reads -> full=1, level=16, almost_full from level 14. A 17th write -> overflow=1, contents unchanged.
- Header 0x0D (len=3) + 3 payload + parity written; 5 reads -> pkt_rem 4,3,2,1,0; pkt_last only with the parity flit; data_out matches order at 1-cycle latency.
- Full FIFO with read+write in the same cycle -> read accepted, write rejected, level 15. Empty FIFO with both -> level 1, data_out holds.
- soft_reset mid-packet (pkt_rem=2, level=5) -> next cycle level 0, empty=1, pkt_rem 0, data_out 0; same-cycle write dropped.
- Read on empty -> underflow=1 and sticky. resetn low one cycle -> all outputs at reset values.
- DATA_W=4, DEPTH=4 instance: random traffic against a scoreboard through multiple pointer wraps; no flag mismatches.
